// File: rtl/control_seq_pkg.sv
// Shared types for the control stage sequencer: stage encoding and per-stage enable masks.
package control_seq_pkg;

    localparam int NUM_STAGES = 5;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4
    } stage_t;

    // Datapath enables; ram_wr is active high here and inverted at the port.
    typedef struct packed {
        logic ir;
        logic pc;
        logic rom1;
        logic ra;
        logic rb;
        logic rz;
        logic rm;
        logic ram_wr;
        logic ry;
        logic rf;
    } en_t;

    localparam en_t MASK_FETCH  = '{ir: 1'b1, pc: 1'b1, rom1: 1'b1, default: 1'b0};
    localparam en_t MASK_DECODE = '{ra: 1'b1, rb: 1'b1, default: 1'b0};
    localparam en_t MASK_EXEC   = '{rz: 1'b1, default: 1'b0};
    localparam en_t MASK_WB     = '{ry: 1'b1, default: 1'b0};

    // Unconditional enables of a stage; data-dependent ones are overlaid by the top.
    function automatic en_t stage_mask(input stage_t s);
        case (s)
            FETCH:     stage_mask = MASK_FETCH;
            DECODE:    stage_mask = MASK_DECODE;
            EXECUTE:   stage_mask = MASK_EXEC;
            WRITEBACK: stage_mask = MASK_WB;
            default:   stage_mask = '0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready MEMORY cycles; hit flags the last allowed one.
module mem_wait_timer #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    localparam int CW = (MAX > 1) ? $clog2(MAX) : 1;

    logic [CW-1:0] cnt;

    assign hit = inc && (cnt == CW'(MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || hit)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/control_stage_sequencer.sv
// Multi-cycle FETCH..WRITEBACK sequencer with stall, memory handshake, NOP skip and retire counter.
// Optional memory-wait timeout is built when MEM_TIMEOUT_EN is defined.
module control_stage_sequencer
    import control_seq_pkg::*;
#(
    parameter int SKIP_NOP    = 1,
    parameter int INSTR_CNT_W = 16,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic                   Clock,
    input  logic                   Reset_L,
    input  logic                   Stall,
    input  logic                   NOP_FLAG,
    input  logic                   WillWriteTo_Memory_H_RF_L,
    input  logic                   Mem_Ready,
    output logic [2:0]             Stage,
    output logic                   IR_Enable,
    output logic                   PC_Enable,
    output logic                   ROM1_Read,
    output logic                   RA_Enable,
    output logic                   RB_Enable,
    output logic                   RZ_Enable,
    output logic                   RM_Enable,
    output logic                   RAM1_Write_L,
    output logic                   RY_Enable,
    output logic                   RF_WRITE,
    output logic                   Instr_Done,
    output logic [INSTR_CNT_W-1:0] Instr_Count,
    output logic                   Mem_Timeout
);

    stage_t state_q, state_d;
    logic   nop_q, nop_d;
    logic   retire;
    logic   timeout_hit;
    logic   timed_out;
    en_t    en;

`ifdef MEM_TIMEOUT_EN
    logic to_q, to_d;

    mem_wait_timer #(.MAX(MEM_TIMEOUT)) u_timer (
        .clk   (Clock),
        .rst_n (Reset_L),
        .inc   (state_q == MEMORY && !Stall && !Mem_Ready),
        .clr   (state_q != MEMORY),
        .hit   (timeout_hit)
    );

    // Remember that this WRITEBACK was entered by timeout, across any stalls in it.
    assign to_d = (state_d == WRITEBACK) && ((state_q == WRITEBACK) ? to_q : timeout_hit);

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) to_q <= 1'b0;
        else          to_q <= to_d;
    end

    assign timed_out   = to_q && (state_q == WRITEBACK);
    assign Mem_Timeout = timed_out;
`else
    assign timeout_hit = 1'b0;
    assign timed_out   = 1'b0;
    assign Mem_Timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        nop_d   = nop_q;
        retire  = 1'b0;
        if (!Stall) begin
            case (state_q)
                FETCH: begin
                    state_d = DECODE;
                    nop_d   = 1'b0;
                end
                DECODE: begin
                    if (NOP_FLAG && SKIP_NOP != 0) begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = EXECUTE;
                        nop_d   = NOP_FLAG;
                    end
                end
                EXECUTE: state_d = MEMORY;
                MEMORY: begin
                    if (Mem_Ready || timeout_hit)
                        state_d = WRITEBACK;
                end
                WRITEBACK: begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q     <= FETCH;
            nop_q       <= 1'b0;
            Instr_Done  <= 1'b0;
            Instr_Count <= '0;
        end else begin
            state_q    <= state_d;
            nop_q      <= nop_d;
            Instr_Done <= retire;
            if (retire && Instr_Count != '1)
                Instr_Count <= Instr_Count + 1'b1;
        end
    end

    // Enables are gated by Reset_L so an asserted reset silences the datapath before any edge.
    always_comb begin
        en = '0;
        if (Reset_L && !Stall) begin
            en = stage_mask(state_q);
            case (state_q)
                EXECUTE: en.rz = !nop_q;
                MEMORY: begin
                    en.ram_wr = WillWriteTo_Memory_H_RF_L && !nop_q;
                    en.rm     = Mem_Ready && !nop_q;
                end
                WRITEBACK: begin
                    en.ry = !nop_q && !timed_out;
                    en.rf = !WillWriteTo_Memory_H_RF_L && !nop_q && !timed_out;
                end
                default: ;
            endcase
        end
    end

    assign Stage        = state_q;
    assign IR_Enable    = en.ir;
    assign PC_Enable    = en.pc;
    assign ROM1_Read    = en.rom1;
    assign RA_Enable    = en.ra;
    assign RB_Enable    = en.rb;
    assign RZ_Enable    = en.rz;
    assign RM_Enable    = en.rm;
    assign RAM1_Write_L = !en.ram_wr;
    assign RY_Enable    = en.ry;
    assign RF_WRITE     = en.rf;

endmodule
